// File: rtl/imem_loader_if.sv
// Interface bundling the imem_loader byte stream, instruction memory
// write port and CPU status lines.
interface imem_loader_if #(
    parameter int INST_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [INST_WIDTH-1:0] wr_data;
    logic                  cpu_hold;
    logic                  done;
    logic                  error;

    modport master (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
    );
endinterface

// File: rtl/imem_loader.sv
// Framed program loader: parses A5/LEN/payload from a byte stream and writes
// instruction words. Define IMEM_LOADER_CHECKSUM_EN for the XOR checksum trailer.
module imem_loader #(
    parameter int INST_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input logic           clk,
    input logic           reset,
    imem_loader_if.master bus
);
    localparam int              BPW       = INST_WIDTH / 8;
    localparam int              BCW       = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [BCW-1:0]  LAST_BYTE = BCW'(BPW - 1);
    localparam logic [31:0]     CAPACITY  = 32'(64'd1 << ADDR_WIDTH);
    localparam logic [7:0]      SYNC      = 8'hA5;

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE} state_t;
    localparam state_t TRAILER = S_CSUM;
`else
    typedef enum logic [2:0] {S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_DONE} state_t;
    localparam state_t TRAILER = S_DONE;
`endif

    state_t                state_q, state_d;
    logic [15:0]           len_q, word_cnt_q;
    logic [BCW-1:0]        byte_cnt_q;
    logic [INST_WIDTH-1:0] asm_q, asm_next;
    logic                  in_ready_q, wr_en_q, cpu_hold_q, done_q, error_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [INST_WIDTH-1:0] wr_data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            csum_q;
`endif

    logic        fire, is_sync, word_last, frame_last, len_over;
    logic [15:0] len_full;

    assign fire       = bus.in_valid && in_ready_q;
    assign is_sync    = (bus.in_data == SYNC);
    assign len_full   = {len_q[15:8], bus.in_data};
    assign len_over   = ({16'd0, len_full} > CAPACITY);
    assign word_last  = (byte_cnt_q == LAST_BYTE);
    assign frame_last = word_last && (word_cnt_q == len_q - 16'd1);
    assign asm_next   = INST_WIDTH'({asm_q, bus.in_data});

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (fire && is_sync) state_d = S_LEN_HI;
            S_LEN_HI: if (fire) state_d = S_LEN_LO;
            S_LEN_LO: if (fire) begin
                if (len_full == 16'd0)  state_d = TRAILER;
                else if (len_over)      state_d = S_IDLE;
                else                    state_d = S_DATA;
            end
            S_DATA:   if (fire && frame_last) state_d = TRAILER;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM:   if (fire) state_d = S_DONE;
`endif
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all registers
    // sample the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            cpu_hold_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != S_DONE);
            done_q     <= (state_d == S_DONE);
            wr_en_q    <= 1'b0;
            // Address advances once the write it labelled has been issued.
            if (wr_en_q) wr_addr_q <= wr_addr_q + ADDR_WIDTH'(1);

            case (state_q)
                S_IDLE: if (fire && is_sync) begin
                    cpu_hold_q <= 1'b1;
                    error_q    <= 1'b0;
                    byte_cnt_q <= '0;
                    word_cnt_q <= '0;
                    wr_addr_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_q     <= '0;
`endif
                end
                S_LEN_HI: if (fire) len_q[15:8] <= bus.in_data;
                S_LEN_LO: if (fire) begin
                    len_q[7:0] <= bus.in_data;
                    if (len_over) error_q <= 1'b1;
                end
                S_DATA: if (fire) begin
                    asm_q <= asm_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_q <= csum_q ^ bus.in_data;
`endif
                    if (word_last) begin
                        byte_cnt_q <= '0;
                        word_cnt_q <= word_cnt_q + 16'd1;
                        wr_en_q    <= 1'b1;
                        wr_data_q  <= asm_next;
                    end else begin
                        byte_cnt_q <= byte_cnt_q + BCW'(1);
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CSUM: if (fire && (bus.in_data != csum_q)) error_q <= 1'b1;
`endif
                S_DONE: cpu_hold_q <= error_q;
                default: ;
            endcase
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.cpu_hold = cpu_hold_q;
    assign bus.done     = done_q;
    assign bus.error    = error_q;
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven frames, hand-written
// timing/reset sequences and randomized frames against a frame-level model.
`timescale 1ns/1ps
module tb_imem_loader;
    localparam int INST_WIDTH = 32;
    localparam int ADDR_WIDTH = 8;
    localparam int BPW        = INST_WIDTH / 8;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    typedef struct {
        logic [ADDR_WIDTH-1:0] addr;
        logic [INST_WIDTH-1:0] data;
    } wr_t;

    typedef struct {
        int len;
        int pattern;     // 0 random, 1 = 11..88, 2 = 01 02 03 04
        int gap;         // 0 none, 1 every other cycle, 2 random
        bit bad;         // corrupt the checksum byte
        int junk;        // leading non-sync bytes
        int exp_writes;
        int exp_done;
        bit exp_err;
        bit exp_hold;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    imem_loader_if #(.INST_WIDTH(INST_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

    imem_loader #(.INST_WIDTH(INST_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   tests_run    = 0;
    int   tests_failed = 0;
    int   cyc          = 0;
    int   done_cnt     = 0;
    int   done_cyc     = 0;
    wr_t  obs_q[$];
    wr_t  exp_q[$];
    int   wr_cyc_q[$];
    int   hs_q[$];
    logic [7:0] pay_q[$];
    logic [7:0] frame_q[$];
    vec_t vecs[9];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.wr_en) begin
            obs_q.push_back('{addr: bus.wr_addr, data: bus.wr_data});
            wr_cyc_q.push_back(cyc);
        end
        if (bus.done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited       = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            check("in_ready_timeout", 64'(bus.in_ready), 64'd1);
            bus.in_valid = 1'b0;
            return;
        end
        hs_q.push_back(cyc);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Frame-level reference: builds the byte stream and the writes it implies.
    task automatic make_frame(input int len, input int pattern, input bit bad, input int junk);
        logic [7:0]            x;
        logic [INST_WIDTH-1:0] w;
        logic [15:0]           l16;
        frame_q.delete();
        pay_q.delete();
        exp_q.delete();
        l16 = len[15:0];
        for (int i = 0; i < junk; i++) frame_q.push_back((i % 2 == 0) ? 8'hFF : 8'h3C);
        frame_q.push_back(8'hA5);
        frame_q.push_back(l16[15:8]);
        frame_q.push_back(l16[7:0]);
        if (len > (1 << ADDR_WIDTH)) return;
        x = 8'h00;
        for (int i = 0; i < len * BPW; i++) begin
            logic [7:0] b;
            if (pattern == 1)      b = 8'(8'h11 * (i % 8 + 1));
            else if (pattern == 2) b = 8'(i + 1);
            else                   b = 8'($urandom_range(0, 255));
            pay_q.push_back(b);
            frame_q.push_back(b);
            x = x ^ b;
        end
        for (int wi = 0; wi < len; wi++) begin
            w = '0;
            for (int k = 0; k < BPW; k++) w = (w << 8) | INST_WIDTH'(pay_q[wi * BPW + k]);
            exp_q.push_back('{addr: ADDR_WIDTH'(wi), data: w});
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        frame_q.push_back(bad ? (x ^ 8'h01) : x);
`endif
    endtask

    function automatic vec_t predict(input int len, input int gap, input bit bad, input int junk);
        vec_t v;
        bit over;
        over         = len > (1 << ADDR_WIDTH);
        v.len        = len;
        v.pattern    = 0;
        v.gap        = gap;
        v.bad        = bad;
        v.junk       = junk;
        v.exp_writes = over ? 0 : len;
        v.exp_done   = over ? 0 : 1;
        v.exp_err    = over || (CSUM_ON && bad);
        v.exp_hold   = v.exp_err;
        return v;
    endfunction

    task automatic send_frame(input int gap);
        foreach (frame_q[i]) begin
            if (gap == 1 || (gap == 2 && $urandom_range(0, 2) == 0)) begin
                bus.in_valid = 1'b0;
                @(negedge clk);
            end
            send_byte(frame_q[i]);
        end
    endtask

    task automatic run_frame(input string name, input vec_t v);
        int d0;
        obs_q.delete();
        wr_cyc_q.delete();
        hs_q.delete();
        d0 = done_cnt;
        make_frame(v.len, v.pattern, v.bad, v.junk);
        send_frame(v.gap);
        repeat (4) @(negedge clk);
        check({name, "_writes"}, 64'(obs_q.size()), 64'(v.exp_writes));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_addr%0d", name, i), 64'(obs_q[i].addr), 64'(exp_q[i].addr));
            check($sformatf("%s_data%0d", name, i), 64'(obs_q[i].data), 64'(exp_q[i].data));
        end
        check({name, "_done"},     64'(done_cnt - d0),  64'(v.exp_done));
        check({name, "_error"},    64'(bus.error),      64'(v.exp_err));
        check({name, "_cpu_hold"}, 64'(bus.cpu_hold),   64'(v.exp_hold));
        check({name, "_in_ready"}, 64'(bus.in_ready),   64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation got stuck, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2,   1, 0, 1'b0, 0, 2,   1, 1'b0,    1'b0};
        vecs[1] = '{2,   1, 1, 1'b0, 0, 2,   1, 1'b0,    1'b0};
        vecs[2] = '{1,   2, 0, 1'b0, 0, 1,   1, 1'b0,    1'b0};
        vecs[3] = '{1,   2, 0, 1'b1, 0, 1,   1, CSUM_ON, CSUM_ON};
        vecs[4] = '{2,   0, 2, 1'b0, 0, 2,   1, 1'b0,    1'b0};
        vecs[5] = '{257, 0, 0, 1'b0, 0, 0,   0, 1'b1,    1'b1};
        vecs[6] = '{0,   0, 0, 1'b0, 0, 0,   1, 1'b0,    1'b0};
        vecs[7] = '{256, 0, 0, 1'b0, 1, 256, 1, 1'b0,    1'b0};
        vecs[8] = '{3,   0, 2, 1'b0, 2, 3,   1, 1'b0,    1'b0};

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_wr_en",    64'(bus.wr_en),    64'd0);
        check("rst_wr_addr",  64'(bus.wr_addr),  64'd0);
        check("rst_wr_data",  64'(bus.wr_data),  64'd0);
        check("rst_cpu_hold", 64'(bus.cpu_hold), 64'd0);
        check("rst_done",     64'(bus.done),     64'd0);
        check("rst_error",    64'(bus.error),    64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_in_ready", 64'(bus.in_ready), 64'd1);

        // Latency of writes, done and cpu_hold edges at full throughput.
        obs_q.delete();
        wr_cyc_q.delete();
        hs_q.delete();
        make_frame(2, 1, 1'b0, 0);
        check("hold_before_sync", 64'(bus.cpu_hold), 64'd0);
        for (int i = 0; i < frame_q.size() - 1; i++) begin
            send_byte(frame_q[i]);
            if (i == 0) check("hold_after_sync", 64'(bus.cpu_hold), 64'd1);
        end
        send_byte(frame_q[frame_q.size() - 1]);
        check("t_done_pulse",    64'(bus.done),     64'd1);
        check("t_hold_in_done",  64'(bus.cpu_hold), 64'd1);
        check("t_ready_in_done", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        check("t_hold_released", 64'(bus.cpu_hold), 64'd0);
        check("t_done_one_cyc",  64'(bus.done),     64'd0);
        repeat (3) @(negedge clk);
        check("t_n_writes", 64'(wr_cyc_q.size()), 64'd2);
        if (wr_cyc_q.size() >= 2) begin
            check("t_wr0_latency", 64'(wr_cyc_q[0] - hs_q[3 + BPW - 1]),     64'd1);
            check("t_wr1_latency", 64'(wr_cyc_q[1] - hs_q[3 + 2 * BPW - 1]), 64'd1);
`ifndef IMEM_LOADER_CHECKSUM_EN
            check("t_done_with_wr1", 64'(done_cyc - wr_cyc_q[1]), 64'd0);
`endif
        end
        check("t_done_latency", 64'(done_cyc - hs_q[frame_q.size() - 1]), 64'd1);

        foreach (vecs[i]) run_frame($sformatf("vec%0d", i), vecs[i]);

        // Reset in the middle of a payload, then resync past junk bytes.
        obs_q.delete();
        wr_cyc_q.delete();
        hs_q.delete();
        make_frame(2, 1, 1'b0, 0);
        for (int i = 0; i < 8; i++) send_byte(frame_q[i]);
        reset        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = frame_q[8];
        @(negedge clk);
        check("mid_rst_wr_en",    64'(bus.wr_en),    64'd0);
        check("mid_rst_cpu_hold", 64'(bus.cpu_hold), 64'd0);
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("mid_rst_wr_addr",  64'(bus.wr_addr),  64'd0);
        check("mid_rst_writes",   64'(obs_q.size()), 64'd1);
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_rst_idle", 64'(bus.in_ready), 64'd1);
        run_frame("resync", '{2, 1, 0, 1'b0, 2, 2, 1, 1'b0, 1'b0});

        for (int r = 0; r < 10; r++) begin
            int len;
            len = (r == 6) ? 300 : int'($urandom_range(0, 6));
            run_frame($sformatf("rnd%0d", r),
                      predict(len, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                              int'($urandom_range(0, 3))));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Writer-side companion to the instruction memory. The CPU only ever reads `instr_mem`; this block fills it at run time from a byte-wide valid/ready stream, such as a UART receiver or testbench driver. It parses a framed program image, assembles bytes into instruction words, and issues sequential word writes. While a load is in progress it holds the CPU off via `cpu_hold`, which gates the CPU state advance in the same way `halted` does.

## Interface
Parameters:
- `INST_WIDTH`, 32: instruction word width in bits. Must be a multiple of 8. `BPW = INST_WIDTH/8` bytes per word.
- `ADDR_WIDTH`, 8: instruction memory address width. Capacity is `2**ADDR_WIDTH` words.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  stream byte valid.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts the byte. A byte transfers on a cycle where `in_valid && in_ready`.
- `wr_en`  out  1  one-cycle instruction memory write strobe.
- `wr_addr`  out  ADDR_WIDTH  word address.
- `wr_data`  out  INST_WIDTH  word to write.
- `cpu_hold`  out  1  CPU must not advance state while high.
- `done`  out  1  one-cycle pulse at the end of a frame.
- `error`  out  1  sticky frame error; cleared on the next sync byte.

## Operation
Frame format, in byte order:
- sync `0xA5`
- `LEN[15:8]`
- `LEN[7:0]`
- `LEN*BPW` payload bytes, each word MSB-first
- one checksum byte, only when `IMEM_LOADER_CHECKSUM_EN` is defined

State machine:
- **IDLE**: `in_ready=1`.
  - Non-`0xA5` bytes are discarded.
  - On `0xA5`: go to LEN_HI, set `cpu_hold=1`, clear `error`, clear the byte counter and `wr_addr` to 0, and clear the checksum accumulator.
- **LEN_HI**: latch the high length byte, go to LEN_LO.
- **LEN_LO**: latch the low length byte, then:
  - `LEN==0`: go to the trailer, which is CSUM if the macro is defined, otherwise DONE.
  - `LEN > 2**ADDR_WIDTH`: set `error`, go to IDLE. `cpu_hold` stays 1.
  - Otherwise: go to DATA.
- **DATA**: shift each accepted byte into a `INST_WIDTH` assembly register, MSB first.
  - On the `BPW`-th byte of a word, the next cycle produces `wr_en=1` with the assembled word and the current `wr_addr`.
  - `wr_addr` increments after each write.
  - After word `LEN-1` is accepted, go to the trailer.
- **CSUM** (macro only): accept one byte and compare it with the running XOR of all payload bytes.
  - Mismatch: set `error`.
  - Either way, go to DONE.
- **DONE**: one cycle.
  - `in_ready=0`, `done=1`.
  - `cpu_hold` drops to 0 if `error==0`, otherwise stays 1.
  - Go to IDLE.

Rules and boundaries:
- `in_ready` is 1 in IDLE, LEN_HI, LEN_LO, DATA and CSUM. It is 0 in DONE and while `reset==0`.
- `in_valid` low stalls in any state with no timeout. Byte gaps of any length are legal.
- The byte counter is `log2(BPW)` bits and wraps at `BPW`. The word counter is 16 bits, compared against `LEN`.
- `wr_addr` never exceeds `2**ADDR_WIDTH - 1`, because of the length check.
- A `0xA5` arriving in LEN or DATA is treated as data. There is no resync mid-frame.
- After an error, `cpu_hold` stays 1 until a later frame completes without error.
- Reset mid-frame:
  - Return to IDLE.
  - Outputs take their reset values.
  - Words already written remain in memory.
  - A pending `wr_en` is dropped.

Reset values: `in_ready=0`, `wr_en=0`, `wr_addr=0`, `wr_data=0`, `cpu_hold=0`, `done=0`, `error=0`.

## Timing
- All outputs are registered.
- The `wr_en` pulse occurs exactly 1 cycle after the handshake of the final byte of its word.
- A write can coincide with the first byte handshake of the next word, or with the cycle spent in CSUM/DONE.
- `done` asserts 1 cycle after the final frame byte is accepted: the last payload byte, or the checksum byte when enabled.
- The final `wr_en` and `done` occur in the same cycle when the checksum is disabled.
- Minimum frame duration: `3 + LEN*BPW (+1) + 1` cycles at full throughput.
- `cpu_hold` rises the cycle after sync is accepted. It falls in the cycle after DONE.

## Configuration
`IMEM_LOADER_CHECKSUM_EN`:
- **Defined**:
  - The CSUM state exists.
  - The frame carries a trailing XOR checksum byte.
  - A mismatch sets `error` and keeps `cpu_hold` high. Words are still written.
- **Undefined**:
  - No checksum byte, no accumulator.
  - DATA (or LEN_LO when `LEN==0`) goes directly to DONE.
  - `error` is only set by length overflow.

## Test plan
- Checksum off, `INST_WIDTH=32`, stream `A5 00 02 11 22 33 44 55 66 77 88`, continuous valid:
  - `wr_en` at addr 0 with data `0x11223344`, then at addr 1 with data `0x55667788`.
  - `done` coincides with the second write.
  - `cpu_hold` is 0 afterwards.
- Same frame with `in_valid` toggling every other cycle:
  - Identical writes and data.
  - No byte is lost or duplicated.
- Checksum on, payload `01 02 03 04`, checksum `04`:
  - `error=0`, `cpu_hold` released.
- Repeat with checksum `05`:
  - `error=1`, `cpu_hold` stays 1.
  - A following valid frame clears both.
- Overflow and empty frames (`ADDR_WIDTH=8`):
  - `A5 01 01` sets `error=1`, with no `wr_en` and a return to IDLE.
  - `A5 00 00` gives a `done` pulse and no writes.
- Reset and resync:
  - Assert `reset` after 5 payload bytes: `wr_en=0`, `cpu_hold=0`, state IDLE.
  - Afterwards, `FF 3C A5 ...` ignores the leading junk bytes and loads correctly.
